// File: rtl/tm1640_seq.sv
// Command sequencer for the TM1640 byte-level driver: data-setting command,
// address + digit burst, display-control command, arbitrated between update,
// brightness and refresh requests.
module tm1640_seq #(
  parameter int NUM_DIGITS     = 9,
  parameter int REFRESH_CYCLES = 500_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    upd_req,
  input  logic                    bri_req,
  input  logic [8*NUM_DIGITS-1:0] digits,
  input  logic [2:0]              brightness,
  input  logic                    disp_on,
  output logic                    drv_valid,
  output logic [7:0]              drv_byte,
  output logic                    drv_first,
  output logic                    drv_last,
  input  logic                    drv_ready,
  output logic                    busy,
  output logic                    done
);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
    $error("tm1640_seq: NUM_DIGITS must be in 1..16");
  end

  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = (REFRESH_CYCLES > 0) ? CW'(REFRESH_CYCLES - 1) : '0;
  localparam logic [3:0] LAST_IDX = 4'(NUM_DIGITS - 1);

  typedef enum logic [2:0] {
    IDLE, CMD_DATA, CMD_ADDR, DIGIT, CMD_CTRL, DONE
  } state_t;

  state_t state, state_n;
  logic [3:0] idx, idx_n, idx_inc;
  logic [8*NUM_DIGITS-1:0] dbuf;
  logic [CW-1:0] cnt;
  logic full_pend, bri_pend;
  logic valid_n, first_n, last_n, busy_n, done_n;
  logic [7:0] byte_n, ctrl_byte;
  logic xfer, refresh_hit, full_go, bri_go, start_full, start_bri, cnt_run;

  assign xfer        = drv_valid && drv_ready;
  assign ctrl_byte   = {1'b1, 3'b000, disp_on, brightness};
  assign idx_inc     = idx + 4'd1;
  assign cnt_run     = (REFRESH_CYCLES != 0) && (state == IDLE) && !full_pend && !bri_pend;
  assign refresh_hit = cnt_run && (cnt == CNT_MAX);
  // Requests seen in IDLE start the sequence directly so the first byte appears next cycle.
  assign full_go     = full_pend || upd_req || refresh_hit;
  assign bri_go      = bri_pend || bri_req;

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    valid_n    = drv_valid;
    byte_n     = drv_byte;
    first_n    = drv_first;
    last_n     = drv_last;
    busy_n     = busy;
    done_n     = 1'b0;
    start_full = 1'b0;
    start_bri  = 1'b0;
    unique case (state)
      IDLE: begin
        if (full_go) begin
          state_n = CMD_DATA; start_full = 1'b1;
          {valid_n, byte_n, first_n, last_n, busy_n} = {1'b1, 8'h40, 1'b1, 1'b1, 1'b1};
        end else if (bri_go) begin
          state_n = CMD_CTRL; start_bri = 1'b1;
          {valid_n, byte_n, first_n, last_n, busy_n} = {1'b1, ctrl_byte, 1'b1, 1'b1, 1'b1};
        end
      end
      CMD_DATA: if (xfer) begin
        state_n = CMD_ADDR;
        {byte_n, first_n, last_n} = {8'hC0, 1'b1, 1'b0};
      end
      CMD_ADDR: if (xfer) begin
        state_n = DIGIT;
        idx_n   = 4'd0;
        {byte_n, first_n, last_n} = {dbuf[7:0], 1'b0, LAST_IDX == 4'd0};
      end
      DIGIT: if (xfer) begin
        if (idx == LAST_IDX) begin
          state_n = CMD_CTRL;
          {byte_n, first_n, last_n} = {ctrl_byte, 1'b1, 1'b1};
        end else begin
          idx_n = idx_inc;
          {byte_n, first_n, last_n} = {dbuf[8*idx_inc +: 8], 1'b0, idx_inc == LAST_IDX};
        end
      end
      CMD_CTRL: if (xfer) begin
        state_n = DONE;
        {valid_n, byte_n, first_n, last_n, busy_n} = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        done_n  = 1'b1;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outside IDLE requests only latch; a full sequence also covers any pending ctrl update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE; idx <= '0; cnt <= '0;
      full_pend <= 1'b1; bri_pend <= 1'b0;
      drv_valid <= 1'b0; drv_byte <= 8'h00; drv_first <= 1'b0; drv_last <= 1'b0;
      busy <= 1'b0; done <= 1'b0;
    end else begin
      state <= state_n; idx <= idx_n;
      drv_valid <= valid_n; drv_byte <= byte_n; drv_first <= first_n; drv_last <= last_n;
      busy <= busy_n; done <= done_n;
      if (state == IDLE) begin
        if (start_full) begin
          full_pend <= 1'b0;
          bri_pend  <= 1'b0;
        end else if (start_bri) begin
          bri_pend  <= 1'b0;
        end
      end else begin
        full_pend <= full_pend || upd_req;
        bri_pend  <= bri_pend || bri_req;
      end
      if (state == DONE || refresh_hit) cnt <= '0;
      else if (cnt_run) cnt <= cnt + 1'b1;
    end
  end

  // Snapshot so a running burst never mixes old and new digit patterns.
  always_ff @(posedge clk) begin
    if (start_full) dbuf <= digits;
  end

endmodule

// File: tb/tb_tm1640_seq.sv
// Directed bench for tm1640_seq: init stream, backpressure, ctrl-only update,
// mid-burst requests, mid-sequence reset, and refresh timing.
module tb_tm1640_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, upd_req, bri_req, disp_on, drv_ready;
  logic [71:0] digits;
  logic [2:0]  brightness;
  logic        drv_valid, drv_first, drv_last, busy, done;
  logic [7:0]  drv_byte;

  logic        rst_b, zero_b, one_b;
  logic        b_valid, b_first, b_last, b_busy, b_done;
  logic [7:0]  b_byte;

  int compared = 0;
  int mismatched = 0;

  localparam logic [71:0] D0 = {9{8'h3F}};
  localparam logic [71:0] D1 = 72'h01_02_04_08_10_20_40_80_3F;
  localparam logic [71:0] D2 = 72'h11_22_33_44_55_66_77_88_99;
  localparam logic [71:0] D3 = 72'hA1_B2_C3_D4_E5_F6_07_18_29;

  tm1640_seq #(.NUM_DIGITS(9), .REFRESH_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .upd_req(upd_req), .bri_req(bri_req), .digits(digits),
    .brightness(brightness), .disp_on(disp_on), .drv_valid(drv_valid),
    .drv_byte(drv_byte), .drv_first(drv_first), .drv_last(drv_last),
    .drv_ready(drv_ready), .busy(busy), .done(done)
  );

  tm1640_seq #(.NUM_DIGITS(9), .REFRESH_CYCLES(100)) dut_refresh (
    .clk(clk), .rst(rst_b), .upd_req(zero_b), .bri_req(zero_b), .digits(D0),
    .brightness(3'd4), .disp_on(one_b), .drv_valid(b_valid),
    .drv_byte(b_byte), .drv_first(b_first), .drv_last(b_last),
    .drv_ready(one_b), .busy(b_busy), .done(b_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max_cycles);
    int n = 0;
    while (!drv_valid && n < max_cycles) begin
      tick();
      n++;
    end
    check_output("wait_valid", {31'd0, drv_valid}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_valid"}, {31'd0, drv_valid}, 32'd0);
    check_output({tag, "_byte"},  {24'd0, drv_byte},  32'd0);
    check_output({tag, "_first"}, {31'd0, drv_first}, 32'd0);
    check_output({tag, "_last"},  {31'd0, drv_last},  32'd0);
    check_output({tag, "_busy"},  {31'd0, busy},      32'd0);
    check_output({tag, "_done"},  {31'd0, done},      32'd0);
  endtask

  // Walks one full 12-byte sequence; optional stall, request injection or reset at a given byte.
  task automatic apply_stimulus(input logic [71:0] d, input logic [7:0] ctrl, input int stall_at,
                                input int inj_at, input logic [71:0] nd, input int rst_at);
    logic [7:0] eb;
    logic ef, el;
    wait_valid(200);
    for (int k = 0; k < 12; k++) begin
      if (k == 0)       {eb, ef, el} = {8'h40, 1'b1, 1'b1};
      else if (k == 1)  {eb, ef, el} = {8'hC0, 1'b1, 1'b0};
      else if (k == 11) {eb, ef, el} = {ctrl, 1'b1, 1'b1};
      else              {eb, ef, el} = {d[8*(k-2) +: 8], 1'b0, k == 10};
      check_output($sformatf("valid[%0d]", k), {31'd0, drv_valid}, 32'd1);
      check_output($sformatf("byte[%0d]", k),  {24'd0, drv_byte},  {24'd0, eb});
      check_output($sformatf("first[%0d]", k), {31'd0, drv_first}, {31'd0, ef});
      check_output($sformatf("last[%0d]", k),  {31'd0, drv_last},  {31'd0, el});
      check_output($sformatf("busy[%0d]", k),  {31'd0, busy},      32'd1);
      if (k == rst_at) begin
        rst = 1'b1;
        tick();
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        return;
      end
      if (k == stall_at) begin
        drv_ready = 1'b0;
        repeat (5) begin
          tick();
          check_output("stall_valid", {31'd0, drv_valid}, 32'd1);
          check_output("stall_byte",  {24'd0, drv_byte},  {24'd0, eb});
          check_output("stall_flags", {30'd0, drv_first, drv_last}, {30'd0, ef, el});
        end
        drv_ready = 1'b1;
      end
      if (k == inj_at) begin
        upd_req = 1'b1;
        bri_req = 1'b1;
        digits  = nd;
      end
      tick();
      upd_req = 1'b0;
      bri_req = 1'b0;
    end
    check_output("seq_done",  {31'd0, done},      32'd1);
    check_output("seq_busy",  {31'd0, busy},      32'd0);
    check_output("seq_valid", {31'd0, drv_valid}, 32'd0);
    tick();
    check_output("done_pulse", {31'd0, done}, 32'd0);
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    int act = 0;
    repeat (cycles) begin
      tick();
      if (drv_valid || busy) act++;
    end
    check_output(tag, act, 32'd0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; rst_b = 1'b1; zero_b = 1'b0; one_b = 1'b1;
    upd_req = 1'b0; bri_req = 1'b0; drv_ready = 1'b1;
    digits = D0; brightness = 3'd4; disp_on = 1'b1;
    repeat (3) tick();

    $display("[TB] reset state and power-up init");
    check_reset_outputs("reset");
    rst = 1'b0;
    apply_stimulus(D0, 8'h8C, -1, -1, D0, -1);
    check_quiet("quiet_after_init", 20);

    $display("[TB] update with backpressure on third digit");
    digits = D1;
    upd_req = 1'b1;
    tick();
    upd_req = 1'b0;
    check_output("upd_latency", {31'd0, drv_valid}, 32'd1);
    apply_stimulus(D1, 8'h8C, 4, -1, D1, -1);

    $display("[TB] brightness-only updates");
    brightness = 3'd7; disp_on = 1'b0; bri_req = 1'b1;
    tick();
    bri_req = 1'b0;
    check_output("bri_valid", {31'd0, drv_valid}, 32'd1);
    check_output("bri_byte",  {24'd0, drv_byte},  32'h87);
    check_output("bri_flags", {30'd0, drv_first, drv_last}, 32'd3);
    check_output("bri_busy",  {31'd0, busy}, 32'd1);
    tick();
    check_output("bri_done",  {31'd0, done}, 32'd1);
    check_output("bri_idle",  {31'd0, drv_valid}, 32'd0);
    tick();
    disp_on = 1'b1; bri_req = 1'b1;
    tick();
    bri_req = 1'b0;
    check_output("bri_on_byte", {24'd0, drv_byte}, 32'h8F);
    tick();
    check_output("bri_on_done", {31'd0, done}, 32'd1);
    check_quiet("quiet_after_bri", 10);

    $display("[TB] requests and digit change mid-burst");
    digits = D2; upd_req = 1'b1;
    tick();
    upd_req = 1'b0;
    apply_stimulus(D2, 8'h8F, -1, 5, D3, -1);
    apply_stimulus(D3, 8'h8F, -1, -1, D3, -1);
    check_quiet("no_ctrl_only", 30);

    $display("[TB] reset during fifth digit");
    upd_req = 1'b1;
    tick();
    upd_req = 1'b0;
    apply_stimulus(D3, 8'h8F, -1, -1, D3, 6);
    tick();
    check_output("restart_byte", {24'd0, drv_byte}, 32'h40);
    apply_stimulus(D3, 8'h8F, -1, -1, D3, -1);
    check_quiet("no_refresh_when_zero", 300);

    $display("[TB] refresh interval");
    rst_b = 1'b0;
    for (int r = 0; r < 2; r++) begin
      cyc = 0;
      while (!b_done && cyc < 400) begin
        tick();
        cyc++;
      end
      check_output($sformatf("refresh_done[%0d]", r), {31'd0, b_done}, 32'd1);
      cyc = 0;
      while (!b_valid && cyc < 300) begin
        tick();
        cyc++;
      end
      check_output($sformatf("refresh_gap[%0d]", r), cyc, 32'd101);
      check_output($sformatf("refresh_byte[%0d]", r), {24'd0, b_byte}, 32'h40);
      check_output($sformatf("refresh_flags[%0d]", r), {30'd0, b_first, b_last}, 32'd3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
